rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, number of waiting cycles before the MDU is force-granted.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports wb_we / wb_rd / wb_data  input  1 / ADDRESS_WIDTH / DATA_WIDTH  pipeline writeback request, no handshake.
REQ-007 SHALL have ports mdu_valid / mdu_rd / mdu_data  input  1 / ADDRESS_WIDTH / DATA_WIDTH  multi-cycle unit result.
REQ-008 SHALL have port mdu_ready  output  1  MDU result accepted this cycle.
REQ-009 SHALL have ports issue_valid / issue_rd  input  1 / ADDRESS_WIDTH  MDU op issued; marks rd busy.
REQ-010 SHALL have ports q_rs1 / q_rs2 / q_rd  input  ADDRESS_WIDTH each  decode-stage hazard query.
REQ-011 SHALL have port hazard  output  1  any queried register busy.
REQ-012 SHALL have port wb_stall  output  1  pipeline must hold its writeback this cycle.
REQ-013 SHALL have ports rf_we / rf_a3 / rf_wd  output  1 / ADDRESS_WIDTH / DATA_WIDTH  register-file write port drive.

Function
REQ-014 SHALL treat wb_we with wb_rd==0 as no writeback request.
REQ-015 SHALL register rf_we/rf_a3/rf_wd: grant in cycle N appears on write port in cycle N+1 (1-cycle latency).
REQ-016 SHALL give writeback priority: wb request present and wb_stall low -> WB granted, mdu_ready=0.
REQ-017 SHALL assert mdu_ready = mdu_valid & (no WB request | state==FORCE), combinationally.
REQ-018 SHALL require MDU to hold mdu_valid/rd/data stable until mdu_ready; transfer = valid & ready.
REQ-019 SHALL, on MDU transfer with mdu_rd==0, complete the handshake with rf_we=0 next cycle.
REQ-020 SHALL implement FSM IDLE/WAIT/FORCE: IDLE->WAIT on mdu_valid & !mdu_ready; WAIT->IDLE on transfer; WAIT->FORCE when wait counter==STARVE_LIMIT; FORCE->IDLE unconditionally after one cycle.
REQ-021 SHALL count consecutive mdu_valid & !mdu_ready cycles, clear on transfer, saturate at STARVE_LIMIT.
REQ-022 SHALL assert wb_stall only in FORCE, and ignore wb_we in that cycle (pipeline re-presents it).
REQ-023 SHALL keep busy bit per register 1..2**ADDRESS_WIDTH-1; x0 never busy.
REQ-024 SHALL set busy[issue_rd] on issue_valid, clear busy[mdu_rd] on MDU transfer; same-register same-cycle set and clear -> set wins.
REQ-025 SHALL assert hazard = busy[q_rs1] | busy[q_rs2] | busy[q_rd], combinational, same cycle.
REQ-026 SHALL keep bypassed nothing: read-after-commit relies on register-file timing, not on this block.

Reset
REQ-027 SHALL, on rst high, immediately force state=IDLE, counter=0, all busy=0, rf_we=0, rf_a3=0, rf_wd=0, wb_stall=0; mdu_ready and hazard follow from cleared state.
REQ-028 SHALL drop any pending MDU transfer when reset asserts mid-wait; no write issued after reset.

Configuration
REQ-029 SHALL, with RF_ARB_STARVE_EN defined, include counter, FORCE state and wb_stall per REQ-020..022.
REQ-030 SHALL, without RF_ARB_STARVE_EN, omit counter and FORCE, tie wb_stall=0; MDU granted only when no WB request.

Structure
REQ-031 SHALL place FSM state enum and default widths in shared package rf_arb_pkg.
REQ-032 SHALL implement busy tracking as sub-module rf_scoreboard (set/clear/query, no arbitration).

Verification
REQ-033 Reset: rst=1 while busy[5]=1 and WAIT -> rf_we=0, hazard=0 for q_rs1=5, state IDLE.
REQ-034 Lone MDU: mdu_valid, rd=7, data=0xDEADBEEF, no WB -> mdu_ready same cycle; next cycle rf_we=1, rf_a3=7, rf_wd=0xDEADBEEF.
REQ-035 Contention: WB rd=3 data=0x11 and MDU rd=9 same cycle -> WB written next cycle, mdu_ready=0, MDU written when wb_we drops.
REQ-036 Starvation (macro on): wb_we=1 every cycle, MDU valid -> wb_stall=1 on cycle STARVE_LIMIT+1, MDU written next cycle; macro off -> never granted, wb_stall stays 0.
REQ-037 Scoreboard: issue rd=12 -> q_rs2=12 gives hazard=1 until MDU rd=12 transfer; issue and transfer of rd=12 same cycle -> still busy.
REQ-038 x0: wb_we rd=0 plus MDU valid -> MDU granted; MDU rd=0 -> handshake done, rf_we=0, no busy change.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package rf_arb_pkg;

   localparam int unsigned DefAddrWidth   = 5;
   localparam int unsigned DefDataWidth   = 32;
   localparam int unsigned DefStarveLimit = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StForce
   } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking for in-flight multi-cycle results; x0 is never busy.
module rf_scoreboard #(
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_en,
   input  logic [ADDRESS_WIDTH-1:0] set_rd,
   input  logic                     clr_en,
   input  logic [ADDRESS_WIDTH-1:0] clr_rd,
   input  logic [ADDRESS_WIDTH-1:0] q_rs1,
   input  logic [ADDRESS_WIDTH-1:0] q_rs2,
   input  logic [ADDRESS_WIDTH-1:0] q_rd,
   output logic                     hazard
);

   localparam int unsigned NumRegs = 1 << ADDRESS_WIDTH;

   logic [NumRegs-1:0] busy_q, busy_d;

   // Set is applied after clear so a same-cycle issue to the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (set_en) begin
         busy_d[set_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign hazard = busy_q[q_rs1] | busy_q[q_rs2] | busy_q[q_rd];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the MDU.
// Optional anti-starvation (counter, FORCE state, wb_stall) enabled by RF_ARB_STARVE_EN.
module rf_wb_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH    = DefDataWidth,
   parameter int unsigned STARVE_LIMIT  = DefStarveLimit
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wb_we,
   input  logic [ADDRESS_WIDTH-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   input  logic                     mdu_valid,
   input  logic [ADDRESS_WIDTH-1:0] mdu_rd,
   input  logic [DATA_WIDTH-1:0]    mdu_data,
   output logic                     mdu_ready,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   input  logic [ADDRESS_WIDTH-1:0] q_rs1,
   input  logic [ADDRESS_WIDTH-1:0] q_rs2,
   input  logic [ADDRESS_WIDTH-1:0] q_rd,
   output logic                     hazard,
   output logic                     wb_stall,
   output logic                     rf_we,
   output logic [ADDRESS_WIDTH-1:0] rf_a3,
   output logic [DATA_WIDTH-1:0]    rf_wd
);

   arb_state_e state_q, state_d;

   logic                     wb_req;
   logic                     wb_grant;
   logic                     mdu_xfer;
   logic                     force_now;
   logic                     rf_we_q;
   logic [ADDRESS_WIDTH-1:0] rf_a3_q;
   logic [DATA_WIDTH-1:0]    rf_wd_q;

   assign wb_req = wb_we & (|wb_rd);

`ifdef RF_ARB_STARVE_EN
   localparam int unsigned CntWidth = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                cnt_sat;

   assign force_now = (state_q == StForce);
   assign cnt_sat   = (cnt_q == CntWidth'(STARVE_LIMIT));

   // Counts consecutive refused cycles; any cycle not waiting restarts the count.
   always_comb begin
      cnt_d = '0;
      if (mdu_valid && !mdu_ready) begin
         cnt_d = cnt_sat ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign force_now = 1'b0;
`endif

   // In FORCE the pipeline holds its writeback, so wb_we is ignored that cycle.
   assign wb_stall  = force_now;
   assign mdu_ready = mdu_valid & (~wb_req | force_now);
   assign mdu_xfer  = mdu_valid & mdu_ready;
   assign wb_grant  = wb_req & ~force_now;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (mdu_valid && !mdu_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mdu_xfer) begin
               state_d = StIdle;
`ifdef RF_ARB_STARVE_EN
            end else if (cnt_sat) begin
               state_d = StForce;
`endif
            end
         end
         StForce: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // MDU results targeting x0 complete the handshake without a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_a3_q <= '0;
         rf_wd_q <= '0;
      end else begin
         rf_we_q <= wb_grant | (mdu_xfer & (|mdu_rd));
         if (wb_grant) begin
            rf_a3_q <= wb_rd;
            rf_wd_q <= wb_data;
         end else if (mdu_xfer) begin
            rf_a3_q <= mdu_rd;
            rf_wd_q <= mdu_data;
         end
      end
   end

   assign rf_we = rf_we_q;
   assign rf_a3 = rf_a3_q;
   assign rf_wd = rf_wd_q;

   rf_scoreboard #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_scoreboard (
      .clk   (clk),
      .rst   (rst),
      .set_en(issue_valid),
      .set_rd(issue_rd),
      .clr_en(mdu_xfer),
      .clr_rd(mdu_rd),
      .q_rs1 (q_rs1),
      .q_rs2 (q_rs2),
      .q_rd  (q_rd),
      .hazard(hazard)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default parameters).
module tb_rf_wb_arbiter;
   import rf_arb_pkg::*;

`ifdef RF_ARB_STARVE_EN
   localparam bit StarveEn = 1'b1;
`else
   localparam bit StarveEn = 1'b0;
`endif
   localparam int Limit = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        mdu_ready;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic [4:0]  q_rs1 = '0;
   logic [4:0]  q_rs2 = '0;
   logic [4:0]  q_rd = '0;
   logic        hazard;
   logic        wb_stall;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .mdu_valid  (mdu_valid),
      .mdu_rd     (mdu_rd),
      .mdu_data   (mdu_data),
      .mdu_ready  (mdu_ready),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .q_rd       (q_rd),
      .hazard     (hazard),
      .wb_stall   (wb_stall),
      .rf_we      (rf_we),
      .rf_a3      (rf_a3),
      .rf_wd      (rf_wd)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and sampled off-edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   initial begin
      // Reset values
      #12;
      check_eq("rst_rf_we", rf_we, 0);
      check_eq("rst_wb_stall", wb_stall, 0);
      rst = 1'b0;
      step();
      check_eq("post_rst_rf_we", rf_we, 0);
      check_eq("post_rst_rf_a3", rf_a3, 0);
      check_eq("post_rst_rf_wd", rf_wd, 0);

      // Reset mid-wait with busy[5] set
      issue_valid = 1'b1; issue_rd = 5'd5;
      step();
      issue_valid = 1'b0;
      q_rs1 = 5'd5;
      #1;
      check_eq("busy5_hazard", hazard, 1);
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
      mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
      #1;
      check_eq("rstwait_ready", mdu_ready, 0);
      step();
      check_eq("rstwait_state", 32'(dut.state_q), 32'(StWait));
      rst = 1'b1;
      #1;
      check_eq("rstasync_rf_we", rf_we, 0);
      check_eq("rstasync_hazard", hazard, 0);
      check_eq("rstasync_state", 32'(dut.state_q), 32'(StIdle));
      idle_inputs();
      step();
      rst = 1'b0;
      step();
      check_eq("rst_nowrite", rf_we, 0);
      q_rs1 = '0;

      // Lone MDU result
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hDEADBEEF;
      #1;
      check_eq("lone_ready", mdu_ready, 1);
      step();
      idle_inputs();
      check_eq("lone_rf_we", rf_we, 1);
      check_eq("lone_rf_a3", rf_a3, 7);
      check_eq("lone_rf_wd", rf_wd, 32'hDEADBEEF);
      step();
      check_eq("lone_after_we", rf_we, 0);

      // WB and MDU contend
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
      #1;
      check_eq("cont_ready0", mdu_ready, 0);
      step();
      check_eq("cont_wb_we", rf_we, 1);
      check_eq("cont_wb_a3", rf_a3, 3);
      check_eq("cont_wb_wd", rf_wd, 32'h11);
      wb_we = 1'b0;
      #1;
      check_eq("cont_ready1", mdu_ready, 1);
      step();
      idle_inputs();
      check_eq("cont_mdu_we", rf_we, 1);
      check_eq("cont_mdu_a3", rf_a3, 9);
      check_eq("cont_mdu_wd", rf_wd, 32'h99);
      step();

      // Starvation: WB every cycle while the MDU waits
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
      mdu_rd = 5'd10; mdu_data = 32'hAA;
      for (int c = 0; c < 8; c++) begin
         mdu_valid = !(StarveEn && c > Limit + 1);
         #1;
         check_eq($sformatf("starve_stall_c%0d", c), wb_stall,
                  (StarveEn && c == Limit + 1) ? 1 : 0);
         check_eq($sformatf("starve_ready_c%0d", c), mdu_ready,
                  (StarveEn && c == Limit + 1) ? 1 : 0);
         step();
         check_eq($sformatf("starve_a3_c%0d", c), rf_a3,
                  (StarveEn && c == Limit + 1) ? 10 : 4);
      end
      wb_we = 1'b0;
      if (!StarveEn) begin
         #1;
         check_eq("starve_late_ready", mdu_ready, 1);
         step();
         check_eq("starve_late_a3", rf_a3, 10);
      end
      idle_inputs();
      step();

      // Scoreboard: issue, same-cycle issue+commit, commit
      issue_valid = 1'b1; issue_rd = 5'd12;
      step();
      issue_valid = 1'b0;
      q_rs2 = 5'd12;
      #1;
      check_eq("sb_busy", hazard, 1);
      issue_valid = 1'b1;
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC0;
      step();
      issue_valid = 1'b0;
      check_eq("sb_setwins", hazard, 1);
      check_eq("sb_rf_a3", rf_a3, 12);
      step();
      mdu_valid = 1'b0;
      #1;
      check_eq("sb_cleared", hazard, 0);
      q_rs2 = '0;
      step();

      // x0 handling
      issue_valid = 1'b1; issue_rd = 5'd13;
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
      mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
      #1;
      check_eq("x0_wb_ready", mdu_ready, 1);
      step();
      issue_valid = 1'b0;
      check_eq("x0_wb_a3", rf_a3, 6);
      check_eq("x0_wb_wd", rf_wd, 32'h66);
      wb_we = 1'b0;
      mdu_rd = 5'd0; mdu_data = 32'h77;
      q_rd = 5'd13;
      #1;
      check_eq("x0_mdu_ready", mdu_ready, 1);
      step();
      idle_inputs();
      check_eq("x0_mdu_we", rf_we, 0);
      check_eq("x0_busy13", hazard, 1);
      q_rd = '0;
      #1;
      check_eq("x0_never_busy", hazard, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
